muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Multi-cycle signed multiply/divide engine. Sits beside the ALU, between the Y register / bus and the 64-bit Z register.
- Takes operand A from Y and operand B from the bus. Produces a 64-bit result that the ALU output mux forwards into Z (Zhigh = HI half, Zlow = LO half).
- The control unit raises `start` in the execute T-state for mul/div, holds its step until `done`, then pulses Zin.
- Replaces the single-cycle combinational mul/div path to shorten the critical path.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.
- CNT_W, 6, iteration-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  1  0 = multiply, 1 = divide; sampled with start.
- a  in  WIDTH  signed multiplicand / dividend (from Y).
- b  in  WIDTH  signed multiplier / divisor (from bus).
- busy  out  1  high from the edge after start is accepted until done deasserts.
- done  out  1  one-cycle completion pulse.
- result  out  2*WIDTH  mul: {HI,LO} = 64-bit signed product; div: HI = remainder, LO = quotient.
- div_zero  out  1  set with done when divisor was 0; cleared on next accepted start.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values (clear, any time, including mid-operation):
  - state = IDLE; busy = 0; done = 0; div_zero = 0; result = 0; counter = 0.
  - Any in-flight operation is abandoned.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - If start = 1 at edge E0: latch a, b, op; counter = 0; clear div_zero.
  - Next state is MUL (op = 0), DIV (op = 1, b != 0), or DONE (op = 1, b == 0).
- MUL:
  - Radix-2 Booth: one recoded bit per edge over a (2*WIDTH+1)-bit product register.
  - counter increments each edge; after WIDTH iterations (edge E32) go to FIX.
- DIV:
  - Latch |a| and |b| plus sign flags at E0.
  - Non-restoring unsigned division, one quotient bit per edge; after WIDTH iterations (E32) go to FIX.
- FIX (edge E33), result register written:
  - Mul: product passes through unchanged.
  - Div: final remainder-restore step. Quotient negated if sign(a) XOR sign(b). Remainder negated if a < 0.
  - Quotient truncates toward zero.
  - Next state is DONE.
- DONE:
  - done = 1 for exactly one cycle; next state is IDLE.
  - Normal latency: done visible after E33 and deasserts after E34.
  - Divide-by-zero: done visible after E1; result = {a, {WIDTH{1'b1}}}; div_zero = 1.
- busy = 1 in MUL, DIV, FIX and DONE; busy = 0 in IDLE.
- start while busy is ignored; no queuing.
- start held high through DONE: a new operation is accepted only at the edge where state is IDLE, i.e. the edge after done.
- result holds its value until the next FIX/DONE write. Operand inputs may change after E0 without effect.
- Overflow case (-2^31) / (-1): quotient = 0x8000_0000, remainder = 0, div_zero = 0.
- Widths:
  - All internal arithmetic is WIDTH+1 bits for the partial remainder and 2*WIDTH+1 bits for the Booth register.
  - No truncation until the final result assignment.

Decomposition:
- Shared package (cpu_pkg):
  - Op encoding constants OP_MUL = 1'b0, OP_DIV = 1'b1.
  - State localparams S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE.
  - The opcode values the control unit decodes to drive start/op.
- One natural sub-module: muldiv_abs (combinational two's-complement abs/negate with sign out). It is used for operand conditioning and final sign fixup.
- The FSM, counter and datapath registers stay in muldiv_unit.

Test Plan:
- Reset mid-operation:
  - Stimulus: op = 0, a = 7, b = 9, start, then assert clear at cycle 10.
  - Required: busy, done and result go to 0 immediately.
  - Then a new start with a = 3, b = -4 gives done after E33 with result = 0xFFFF_FFFF_FFFF_FFF4.
- Multiply:
  - Stimulus: a = 0x8000_0000, b = 0x8000_0000.
  - Required: result = 0x4000_0000_0000_0000; done high for exactly one cycle, 33 edges after the start edge.
- Signed divide:
  - Stimulus: a = -17, b = 5.
  - Required: LO = 0xFFFF_FFFD (-3), HI = 0xFFFF_FFFE (-2).
  - Also a = 17, b = -5 → LO = -3, HI = 2.
- Divide by zero:
  - Stimulus: a = 0x1234_5678, b = 0.
  - Required: done after E1, result = 0x1234_5678_FFFF_FFFF, div_zero = 1.
  - A following mul start clears div_zero.
- Overflow divide:
  - Stimulus: a = 0x8000_0000, b = 0xFFFF_FFFF.
  - Required: LO = 0x8000_0000, HI = 0, div_zero = 0.
- Back-to-back and ignored start:
  - Stimulus: start held high continuously with op = 0, a = 2, b = 3.
  - Required: start pulses during busy are ignored; the second operation is accepted at the edge after done; two done pulses 35 edges apart; result = 6 both times.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: mul/div opcodes, op select and engine states.
package cpu_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam logic [4:0] OPC_MUL = 5'd14;
  localparam logic [4:0] OPC_DIV = 5'd15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } mdu_state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/completion bundle between control unit and mul/div engine.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);

  logic               start;
  logic               op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic               div_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, div_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, div_zero
  );

endinterface

// File: rtl/muldiv_abs.sv
// Two's-complement conditional negate; abs when negate = sign of val.
module muldiv_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val,
  input  logic             negate,
  output logic [WIDTH-1:0] res,
  output logic             sign
);

  assign res  = negate ? (~val + WIDTH'(1)) : val;
  assign sign = val[WIDTH-1];

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (non-restoring).
module muldiv_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic         clock,
  input logic         clear,
  muldiv_unit_if.slave io
);

  mdu_state_t         state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   mq;
  logic               qm1;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   a_r;
  logic               op_r;
  logic               q_neg;
  logic               r_neg;
  logic               busy;
  logic               done;
  logic               div_zero;
  logic [2*WIDTH-1:0] result;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               a_sgn;
  logic               b_sgn;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;
  logic [WIDTH-1:0]   r_low;
  logic               q_sgn_unused;
  logic               r_sgn_unused;
  logic [WIDTH:0]     m_ext;
  logic [WIDTH:0]     b_sum;
  logic [WIDTH:0]     d_sh;
  logic [WIDTH:0]     d_nxt;
  logic               last;

  muldiv_abs #(.WIDTH(WIDTH)) u_abs_a (
    .val(io.a), .negate(io.a[WIDTH-1]),
    .res(a_mag), .sign(a_sgn)
  );

  muldiv_abs #(.WIDTH(WIDTH)) u_abs_b (
    .val(io.b), .negate(io.b[WIDTH-1]),
    .res(b_mag), .sign(b_sgn)
  );

  muldiv_abs #(.WIDTH(WIDTH)) u_fix_q (
    .val(mq), .negate(q_neg),
    .res(q_fix), .sign(q_sgn_unused)
  );

  muldiv_abs #(.WIDTH(WIDTH)) u_fix_r (
    .val(r_low), .negate(r_neg),
    .res(r_fix), .sign(r_sgn_unused)
  );

  assign m_ext = {mcand[WIDTH-1], mcand};
  assign last  = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    b_sum = acc;
    case ({mq[0], qm1})
      2'b01:   b_sum = acc + m_ext;
      2'b10:   b_sum = acc - m_ext;
      default: b_sum = acc;
    endcase
  end

  // |rem| < divisor <= 2^(WIDTH-1), so dropping acc[WIDTH] on shift is lossless
  assign d_sh  = {acc[WIDTH-1:0], mq[WIDTH-1]};
  assign d_nxt = acc[WIDTH] ? d_sh + {1'b0, mcand}
                            : d_sh - {1'b0, mcand};
  assign r_low = acc[WIDTH-1:0] + (acc[WIDTH] ? mcand : '0);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      mq       <= '0;
      qm1      <= 1'b0;
      mcand    <= '0;
      a_r      <= '0;
      op_r     <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      result   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (io.start) begin
            op_r     <= io.op;
            a_r      <= io.a;
            cnt      <= '0;
            acc      <= '0;
            qm1      <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b1;
            if (io.op == OP_MUL) begin
              mq    <= io.b;
              mcand <= io.a;
              state <= S_MUL;
            end else begin
              mq    <= a_mag;
              mcand <= b_mag;
              q_neg <= a_sgn ^ b_sgn;
              r_neg <= a_sgn;
              state <= (io.b == '0) ? S_DONE : S_DIV;
            end
          end
        end
        S_MUL: begin
          acc <= {b_sum[WIDTH], b_sum[WIDTH:1]};
          mq  <= {b_sum[0], mq[WIDTH-1:1]};
          qm1 <= mq[0];
          cnt <= cnt + 1'b1;
          if (last) state <= S_FIX;
        end
        S_DIV: begin
          acc <= d_nxt;
          mq  <= {mq[WIDTH-2:0], ~d_nxt[WIDTH]};
          cnt <= cnt + 1'b1;
          if (last) state <= S_FIX;
        end
        S_FIX: begin
          result <= op_r ? {r_fix, q_fix}
                         : {acc[WIDTH-1:0], mq};
          done   <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          // divide-by-zero arrives here with done still low
          if (done) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            result   <= {a_r, {WIDTH{1'b1}}};
            div_zero <= 1'b1;
            done     <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign io.busy     = busy;
  assign io.done     = done;
  assign io.result   = result;
  assign io.div_zero = div_zero;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit.
module tb_muldiv_unit;
  import cpu_pkg::*;

  typedef struct packed {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic        dz;
    int          lat;
  } vec_t;

  localparam int NV = 15;

  logic clock;
  logic clear;
  int   checks;
  int   failures;
  vec_t vecs [NV];

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clock(clock),
    .clear(clear),
    .io(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic run_op(input logic op, input logic [31:0] a,
                        input logic [31:0] b, output int lat,
                        output logic [63:0] res, output logic dz,
                        output logic one_cyc, output logic busy_e1,
                        output logic idle_after);
    @(negedge clock);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    bus.a     = 32'hDEAD_BEEF;
    bus.b     = 32'h5A5A_5A5A;
    busy_e1   = bus.busy;
    lat       = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clock);
      #1;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    res = bus.result;
    dz  = bus.div_zero;
    @(posedge clock);
    #1;
    one_cyc    = !bus.done;
    idle_after = !bus.busy;
  endtask

  int          lat;
  logic [63:0] res;
  logic        dz;
  logic        one_cyc;
  logic        busy_e1;
  logic        idle_after;
  int          n;
  int          t1;
  int          t2;
  logic [63:0] r1;
  logic [63:0] r2;

  initial begin
    checks    = 0;
    failures  = 0;
    clear     = 1'b1;
    bus.start = 1'b0;
    bus.op    = OP_MUL;
    bus.a     = '0;
    bus.b     = '0;

    vecs[0]  = '{OP_MUL, 32'h8000_0000, 32'h8000_0000,
                 64'h4000_0000_0000_0000, 1'b0, 33};
    vecs[1]  = '{OP_MUL, 32'h0000_0003, 32'hFFFF_FFFC,
                 64'hFFFF_FFFF_FFFF_FFF4, 1'b0, 33};
    vecs[2]  = '{OP_MUL, 32'h0000_0002, 32'h0000_0003,
                 64'h0000_0000_0000_0006, 1'b0, 33};
    vecs[3]  = '{OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 64'h0000_0000_0000_0001, 1'b0, 33};
    vecs[4]  = '{OP_MUL, 32'h7FFF_FFFF, 32'h8000_0000,
                 64'hC000_0000_8000_0000, 1'b0, 33};
    vecs[5]  = '{OP_DIV, 32'hFFFF_FFEF, 32'h0000_0005,
                 64'hFFFF_FFFE_FFFF_FFFD, 1'b0, 33};
    vecs[6]  = '{OP_DIV, 32'h0000_0011, 32'hFFFF_FFFB,
                 64'h0000_0002_FFFF_FFFD, 1'b0, 33};
    vecs[7]  = '{OP_DIV, 32'hFFFF_FFEF, 32'hFFFF_FFFB,
                 64'hFFFF_FFFE_0000_0003, 1'b0, 33};
    vecs[8]  = '{OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
                 64'h0000_0000_8000_0000, 1'b0, 33};
    vecs[9]  = '{OP_DIV, 32'h1234_5678, 32'h0000_0000,
                 64'h1234_5678_FFFF_FFFF, 1'b1, 1};
    vecs[10] = '{OP_MUL, 32'h0000_0007, 32'h0000_0009,
                 64'h0000_0000_0000_003F, 1'b0, 33};
    vecs[11] = '{OP_DIV, 32'h0000_0064, 32'h0000_0007,
                 64'h0000_0002_0000_000E, 1'b0, 33};
    vecs[12] = '{OP_DIV, 32'h0000_0005, 32'h0000_0011,
                 64'h0000_0005_0000_0000, 1'b0, 33};
    vecs[13] = '{OP_DIV, 32'h8000_0000, 32'h0000_0001,
                 64'h0000_0000_8000_0000, 1'b0, 33};
    vecs[14] = '{OP_DIV, 32'h7FFF_FFFF, 32'h0000_0002,
                 64'h0000_0001_3FFF_FFFF, 1'b0, 33};

    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_result", bus.result, 64'd0);
    chk("rst_dz", 64'(bus.div_zero), 64'd0);
    @(negedge clock);
    clear = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b,
             lat, res, dz, one_cyc, busy_e1, idle_after);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_res", i), res, vecs[i].res);
      chk($sformatf("v%0d_dz", i), 64'(dz), 64'(vecs[i].dz));
      chk($sformatf("v%0d_pulse", i), 64'(one_cyc), 64'd1);
      chk($sformatf("v%0d_busy", i), 64'(busy_e1), 64'd1);
      chk($sformatf("v%0d_idle", i), 64'(idle_after), 64'd1);
    end

    // Clear mid-operation
    @(negedge clock);
    bus.start = 1'b1;
    bus.op    = OP_MUL;
    bus.a     = 32'd7;
    bus.b     = 32'd9;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    clear = 1'b1;
    #1;
    chk("clr_busy", 64'(bus.busy), 64'd0);
    chk("clr_done", 64'(bus.done), 64'd0);
    chk("clr_result", bus.result, 64'd0);
    @(negedge clock);
    clear = 1'b0;
    run_op(OP_MUL, 32'd3, 32'hFFFF_FFFC,
           lat, res, dz, one_cyc, busy_e1, idle_after);
    chk("clr_lat", 64'(lat), 64'd33);
    chk("clr_res", res, 64'hFFFF_FFFF_FFFF_FFF4);

    // start held high: second op accepted the edge after done
    @(negedge clock);
    bus.start = 1'b1;
    bus.op    = OP_MUL;
    bus.a     = 32'd2;
    bus.b     = 32'd3;
    n  = 0;
    t1 = -1;
    t2 = -1;
    r1 = '0;
    r2 = '0;
    for (int e = 0; e < 100 && n < 2; e++) begin
      @(posedge clock);
      #1;
      if (bus.done) begin
        if (n == 0) begin
          t1 = e;
          r1 = bus.result;
        end else begin
          t2 = e;
          r2 = bus.result;
        end
        n++;
      end
    end
    bus.start = 1'b0;
    chk("b2b_count", 64'(n), 64'd2);
    chk("b2b_first", 64'(t1), 64'd33);
    chk("b2b_gap", 64'(t2 - t1), 64'd35);
    chk("b2b_res1", r1, 64'd6);
    chk("b2b_res2", r2, 64'd6);
    @(posedge clock);
    #1;
    chk("b2b_idle", 64'(bus.busy), 64'd0);
    @(posedge clock);
    #1;
    chk("b2b_no_third", 64'(bus.busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
